// File: rtl/sram_ctrl_defs_pkg.sv
// sram_ctrl_defs: shared definitions for the SRAM access controller.
//   state_t        - controller FSM states
//   STROBE_ACTIVE  - level of an asserted active-low SRAM strobe
//   STROBE_IDLE    - level of a deasserted active-low SRAM strobe
//   rr_next()      - round-robin successor index
//   max3()         - largest of three values, used to size the phase counter
package sram_ctrl_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WEND  = 3'd3,
        ST_READ  = 3'd4,
        ST_RINC  = 3'd5,
        ST_DROP  = 3'd6
    } state_t;

    localparam logic STROBE_ACTIVE = 1'b0;
    localparam logic STROBE_IDLE   = 1'b1;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for the write clients.
//   i_clk      - clock, posedge
//   i_rst      - synchronous active-high reset (pointer back to client 0)
//   i_req      - per-client request vector
//   i_advance  - pulse: the current grant is taken, move pointer past it
//   o_grant    - one-hot grant (zero when no request)
//   o_index    - binary index of the granted client
//   o_valid    - at least one request present
module rr_arbiter
    import sram_ctrl_defs::*;
#(
    parameter int unsigned NUM_CLIENTS = 2,
    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic                   i_advance,
    output logic [NUM_CLIENTS-1:0] o_grant,
    output logic [IDX_W-1:0]       o_index,
    output logic                   o_valid
);

    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       w_index;
    logic                   w_found;
    logic [NUM_CLIENTS-1:0] w_grant;

    // First requester at or after the pointer, searching upwards with wrap.
    always_comb begin
        w_found = 1'b0;
        w_index = '0;
        for (int unsigned off = 0; off < NUM_CLIENTS; off++) begin
            if (!w_found && i_req[IDX_W'((32'(r_ptr) + off) % NUM_CLIENTS)]) begin
                w_found = 1'b1;
                w_index = IDX_W'((32'(r_ptr) + off) % NUM_CLIENTS);
            end
        end
        w_grant = w_found ? (NUM_CLIENTS'(1) << w_index) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= IDX_W'(rr_next(32'(w_index), NUM_CLIENTS));
        end
    end

    assign o_grant = w_grant;
    assign o_index = w_index;
    assign o_valid = w_found;

endmodule

// File: rtl/sram_access_controller.sv
// sram_access_controller: N write clients (round-robin) plus one read port onto an
// asynchronous SRAM, with an integrated address counter (saturate or wrap).
//   CLOCK, RESET         - posedge clock, synchronous active-high reset
//   WR_REQ/WR_DATA       - per-client level write request and data, held until WR_ACK
//   WR_ACK               - per-client one-cycle completion (or drop while FULL)
//   RD_REQ               - level read request, held until RD_VALID
//   RD_DATA/RD_VALID     - captured read byte, pulse when updated
//   ADDR_LOAD/ADDR_VAL   - counter load pulse and value (deferred while busy)
//   SRAM_A, SRAM_DQ_*    - SRAM address and data pad control
//   SRAM_WE_n, SRAM_OE_n - SRAM strobes, active-low, registered
//   EMPTY, FULL, OVERRUN, WRAPPED, BUSY - status
module sram_access_controller
    import sram_ctrl_defs::*;
#(
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned WE_CYCLES   = 1,
    parameter int unsigned RD_CYCLES   = 2,
    parameter int unsigned WRAP        = 0
) (
    input  logic                              CLOCK,
    input  logic                              RESET,
    input  logic [NUM_CLIENTS-1:0]            WR_REQ,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] WR_DATA,
    output logic [NUM_CLIENTS-1:0]            WR_ACK,
    input  logic                              RD_REQ,
    output logic [DATA_WIDTH-1:0]             RD_DATA,
    output logic                              RD_VALID,
    input  logic                              ADDR_LOAD,
    input  logic [ADDR_WIDTH-1:0]             ADDR_VAL,
    output logic [ADDR_WIDTH-1:0]             SRAM_A,
    output logic [DATA_WIDTH-1:0]             SRAM_DQ_OUT,
    input  logic [DATA_WIDTH-1:0]             SRAM_DQ_IN,
    output logic                              SRAM_DQ_OE,
    output logic                              SRAM_WE_n,
    output logic                              SRAM_OE_n,
    output logic                              EMPTY,
    output logic                              FULL,
    output logic                              OVERRUN,
    output logic                              WRAPPED,
    output logic                              BUSY
);

    localparam int unsigned IDX_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned MAX_CYC = max3(TURN_CYCLES, WE_CYCLES, RD_CYCLES);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [CNT_W-1:0]         r_cnt;

    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [ADDR_WIDTH-1:0]    r_load_val;
    logic                     r_load_pend;
    logic                     r_full;
    logic                     r_overrun;
    logic                     r_wrapped;

    logic [NUM_CLIENTS-1:0]   r_grant;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rd_data;

    logic                     r_we_n;
    logic                     r_oe_n;
    logic                     r_dq_oe;
    logic                     w_we_n;
    logic                     w_oe_n;
    logic                     w_dq_oe;

    logic [NUM_CLIENTS-1:0]   w_arb_grant;
    logic [IDX_W-1:0]         w_arb_index;
    logic                     w_arb_valid;

    logic                     w_idle;
    logic                     w_load_now;
    logic [ADDR_WIDTH-1:0]    w_load_value;
    logic                     w_start_wr;
    logic                     w_start_rd;
    logic                     w_inc;
    logic                     w_at_top;

    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_arb (
        .i_clk     (CLOCK),
        .i_rst     (RESET),
        .i_req     (WR_REQ),
        .i_advance (w_start_wr),
        .o_grant   (w_arb_grant),
        .o_index   (w_arb_index),
        .o_valid   (w_arb_valid)
    );

    // IDLE decisions: a load (fresh or deferred) takes the whole IDLE cycle,
    // then writes beat reads.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_load_now   = w_idle && (ADDR_LOAD || r_load_pend);
    assign w_load_value = ADDR_LOAD ? ADDR_VAL : r_load_val;
    assign w_start_wr   = w_idle && !w_load_now && w_arb_valid;
    assign w_start_rd   = w_idle && !w_load_now && !w_arb_valid && RD_REQ;
    // Increment on the edge leaving WEND/RINC so SRAM_A holds through the access.
    assign w_inc        = (r_state == ST_WEND) || (r_state == ST_RINC);
    assign w_at_top     = (r_addr == '1);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, and the strobe levels that go with the next state so the
    // pad strobes come straight from flops.
    always_comb begin
        w_next  = r_state;
        w_we_n  = STROBE_IDLE;
        w_oe_n  = STROBE_ACTIVE;
        w_dq_oe = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_wr) begin
                    w_next = r_full ? ST_DROP : ST_TURN;
                end else if (w_start_rd) begin
                    w_next = ST_READ;
                end
            end
            ST_TURN: begin
                if (r_cnt == CNT_W'(TURN_CYCLES - 1)) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_cnt == CNT_W'(WE_CYCLES - 1)) w_next = ST_WEND;
            end
            ST_WEND: w_next = ST_IDLE;
            ST_READ: begin
                if (r_cnt == CNT_W'(RD_CYCLES - 1)) w_next = ST_RINC;
            end
            ST_RINC: w_next = ST_IDLE;
            ST_DROP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase

        case (w_next)
            ST_TURN: begin
                w_oe_n  = STROBE_IDLE;
                w_dq_oe = 1'b1;
            end
            ST_WRITE: begin
                w_we_n  = STROBE_ACTIVE;
                w_oe_n  = STROBE_IDLE;
                w_dq_oe = 1'b1;
            end
            ST_WEND: begin
                w_dq_oe = 1'b1;
            end
            default: begin
                w_we_n  = STROBE_IDLE;
                w_oe_n  = STROBE_ACTIVE;
                w_dq_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_we_n  <= STROBE_IDLE;
            r_oe_n  <= STROBE_ACTIVE;
            r_dq_oe <= 1'b0;
        end else begin
            r_we_n  <= w_we_n;
            r_oe_n  <= w_oe_n;
            r_dq_oe <= w_dq_oe;
        end
    end

    // Phase counter: cycles spent in the current timed state.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == ST_TURN || r_state == ST_WRITE || r_state == ST_READ) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Grant capture, address counter, deferred load and sticky flags.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_grant     <= '0;
            r_wdata     <= '0;
            r_rd_data   <= '0;
            r_addr      <= '0;
            r_load_val  <= '0;
            r_load_pend <= 1'b0;
            r_full      <= 1'b0;
            r_overrun   <= 1'b0;
            r_wrapped   <= 1'b0;
        end else begin
            if (w_start_wr) begin
                r_grant <= w_arb_grant;
                r_wdata <= WR_DATA[32'(w_arb_index)*DATA_WIDTH +: DATA_WIDTH];
            end

            if (!w_idle && ADDR_LOAD) begin
                r_load_pend <= 1'b1;
                r_load_val  <= ADDR_VAL;
            end else if (w_load_now) begin
                r_load_pend <= 1'b0;
            end

            if (w_load_now) begin
                r_addr    <= w_load_value;
                r_full    <= 1'b0;
                r_overrun <= 1'b0;
                r_wrapped <= 1'b0;
            end else if (w_inc) begin
                if (w_at_top) begin
                    if (WRAP != 0) begin
                        r_addr    <= '0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_full    <= 1'b1;
                    end
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end

            if (r_state == ST_DROP) begin
                r_overrun <= 1'b1;
            end

            if (r_state == ST_READ && r_cnt == CNT_W'(RD_CYCLES - 1)) begin
                r_rd_data <= SRAM_DQ_IN;
            end
        end
    end

    assign WR_ACK      = (r_state == ST_WEND || r_state == ST_DROP) ? r_grant : '0;
    assign RD_VALID    = (r_state == ST_RINC);
    assign RD_DATA     = r_rd_data;
    assign SRAM_A      = r_addr;
    assign SRAM_DQ_OUT = r_wdata;
    assign SRAM_DQ_OE  = r_dq_oe;
    assign SRAM_WE_n   = r_we_n;
    assign SRAM_OE_n   = r_oe_n;
    assign EMPTY       = (r_addr == '0);
    assign FULL        = r_full;
    assign OVERRUN     = r_overrun;
    assign WRAPPED     = r_wrapped;
    assign BUSY        = !w_idle;

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller: a saturating instance (a_*) with its
// own SRAM model, and a wrapping instance (b_*) sharing the same stimulus.
module tb_sram_access_controller;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [1:0]  WR_REQ;
    logic [15:0] WR_DATA;
    logic        RD_REQ;
    logic        ADDR_LOAD;
    logic [18:0] ADDR_VAL;
    logic [7:0]  SRAM_DQ_IN = 8'h00;

    logic [1:0]  a_wr_ack, b_wr_ack;
    logic [7:0]  a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid;
    logic [18:0] a_addr, b_addr;
    logic [7:0]  a_dq_out, b_dq_out;
    logic        a_dq_oe, b_dq_oe, a_we_n, b_we_n, a_oe_n, b_oe_n;
    logic        a_empty, b_empty, a_full, b_full, a_overrun, b_overrun;
    logic        a_wrapped, b_wrapped, a_busy, b_busy;

    always #5 CLOCK = ~CLOCK;

    sram_access_controller #(.WRAP(0)) dut_sat (
        .CLOCK(CLOCK), .RESET(RESET), .WR_REQ(WR_REQ), .WR_DATA(WR_DATA), .WR_ACK(a_wr_ack),
        .RD_REQ(RD_REQ), .RD_DATA(a_rd_data), .RD_VALID(a_rd_valid), .ADDR_LOAD(ADDR_LOAD),
        .ADDR_VAL(ADDR_VAL), .SRAM_A(a_addr), .SRAM_DQ_OUT(a_dq_out), .SRAM_DQ_IN(SRAM_DQ_IN),
        .SRAM_DQ_OE(a_dq_oe), .SRAM_WE_n(a_we_n), .SRAM_OE_n(a_oe_n), .EMPTY(a_empty),
        .FULL(a_full), .OVERRUN(a_overrun), .WRAPPED(a_wrapped), .BUSY(a_busy)
    );

    sram_access_controller #(.WRAP(1)) dut_wrap (
        .CLOCK(CLOCK), .RESET(RESET), .WR_REQ(WR_REQ), .WR_DATA(WR_DATA), .WR_ACK(b_wr_ack),
        .RD_REQ(RD_REQ), .RD_DATA(b_rd_data), .RD_VALID(b_rd_valid), .ADDR_LOAD(ADDR_LOAD),
        .ADDR_VAL(ADDR_VAL), .SRAM_A(b_addr), .SRAM_DQ_OUT(b_dq_out), .SRAM_DQ_IN(SRAM_DQ_IN),
        .SRAM_DQ_OE(b_dq_oe), .SRAM_WE_n(b_we_n), .SRAM_OE_n(b_oe_n), .EMPTY(b_empty),
        .FULL(b_full), .OVERRUN(b_overrun), .WRAPPED(b_wrapped), .BUSY(b_busy)
    );

    typedef struct {
        int unsigned client;
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  mem [logic [18:0]];

    int n_assert = 0;
    int n_fail   = 0;
    int we_low   = 0;
    int rd_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input int unsigned client, input logic [18:0] addr,
                           input logic [7:0] data);
        wr_exp_t e;
        e.client = client;
        e.addr   = addr;
        e.data   = data;
        wr_q.push_back(e);
    endtask

    // Pop the oldest expected write and check it against the ack and the SRAM model.
    task automatic pop_wr(input logic [1:0] ack);
        wr_exp_t     e;
        logic [8:0]  got;
        if (wr_q.size() == 0) begin
            chk("wr_unexpected_ack", 32'(ack), 32'd0);
            return;
        end
        e = wr_q.pop_front();
        got = mem.exists(e.addr) ? {1'b0, mem[e.addr]} : 9'h100;
        chk("wr_ack_client", 32'(ack), 32'(2'b01 << e.client));
        chk("wr_ack_addr", 32'(a_addr), 32'(e.addr));
        chk("wr_mem_data", 32'(got), 32'({1'b0, e.data}));
    endtask

    task automatic wait_wr_ack(input int bound, output logic [1:0] ack);
        ack = '0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLOCK);
            if (a_wr_ack != 2'b00) begin
                ack = a_wr_ack;
                return;
            end
        end
        chk("wr_ack_timeout", 32'(a_wr_ack != 2'b00), 32'd1);
    endtask

    task automatic wait_we_low(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge CLOCK);
            if (a_we_n === 1'b0) return;
        end
        chk("we_low_timeout", 32'(a_we_n), 32'd0);
    endtask

    // SRAM model for the saturating instance plus strobe protocol checks.
    always @(negedge CLOCK) begin
        if (a_we_n === 1'b0) begin
            mem[a_addr] = a_dq_out;
            we_low++;
            chk("we_strobes", 32'({a_dq_oe, a_oe_n}), 32'd3);
        end else if (we_low != 0) begin
            chk("we_width", 32'(we_low), 32'd1);
            we_low = 0;
        end
        if (a_rd_valid === 1'b1) rd_pulses++;
        SRAM_DQ_IN = mem.exists(a_addr) ? mem[a_addr] : 8'h00;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ack;
        logic       got_rd;

        RESET = 1'b1; WR_REQ = '0; WR_DATA = '0; RD_REQ = 1'b0;
        ADDR_LOAD = 1'b0; ADDR_VAL = '0;
        repeat (3) @(negedge CLOCK);

        chk("rst_we_n", 32'(a_we_n), 32'd1);
        chk("rst_oe_n", 32'(a_oe_n), 32'd0);
        chk("rst_dq_oe", 32'(a_dq_oe), 32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_flags", 32'({a_full, a_overrun, a_wrapped, a_busy}), 32'd0);
        chk("rst_strobes_out", 32'({a_wr_ack, a_rd_valid}), 32'd0);
        chk("rst_rd_data", 32'(a_rd_data), 32'd0);
        RESET = 1'b0;
        @(negedge CLOCK);

        // Single write, cycle by cycle.
        WR_DATA[7:0] = 8'hA5; WR_REQ = 2'b01;
        push_wr(0, 19'h0, 8'hA5);
        @(negedge CLOCK);
        chk("turn_strobes", 32'({a_we_n, a_oe_n, a_dq_oe, a_busy, a_wr_ack}), 32'b111100);
        @(negedge CLOCK);
        chk("write_we_n", 32'(a_we_n), 32'd0);
        chk("write_dq", 32'(a_dq_out), 32'hA5);
        chk("write_addr", 32'(a_addr), 32'd0);
        @(negedge CLOCK);
        chk("wend_strobes", 32'({a_we_n, a_oe_n, a_dq_oe}), 32'b101);
        pop_wr(a_wr_ack);
        WR_REQ = 2'b00;
        @(negedge CLOCK);
        chk("after_wr_addr", 32'(a_addr), 32'd1);
        chk("after_wr_idle", 32'({a_busy, a_wr_ack, a_empty}), 32'd0);

        // Round-robin from a fresh pointer, two clients continuously requesting.
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        WR_DATA = {8'h20, 8'h10}; WR_REQ = 2'b11;
        push_wr(0, 19'd0, 8'h10);
        push_wr(1, 19'd1, 8'h20);
        push_wr(0, 19'd2, 8'h11);
        push_wr(1, 19'd3, 8'h21);
        for (int k = 0; k < 4; k++) begin
            wait_wr_ack(20, ack);
            if (ack != 2'b00) begin
                pop_wr(ack);
                if (ack[0]) WR_DATA[7:0]  = 8'h11;
                if (ack[1]) WR_DATA[15:8] = 8'h21;
            end
        end
        WR_REQ = 2'b00;
        @(negedge CLOCK);
        chk("rr_final_addr", 32'(a_addr), 32'd4);

        // Load in IDLE, then simultaneous write and read: write goes first.
        ADDR_LOAD = 1'b1; ADDR_VAL = 19'd2;
        @(negedge CLOCK);
        ADDR_LOAD = 1'b0;
        chk("load_idle", 32'(a_addr), 32'd2);
        WR_DATA[7:0] = 8'h5C; WR_REQ = 2'b01; RD_REQ = 1'b1;
        push_wr(0, 19'd2, 8'h5C);
        rd_q.push_back(8'h21);
        wait_wr_ack(20, ack);
        if (ack != 2'b00) pop_wr(ack);
        chk("rd_after_wr", 32'(rd_pulses), 32'd0);
        WR_REQ = 2'b00;
        got_rd = 1'b0;
        for (int i = 0; i < 20 && !got_rd; i++) begin
            @(negedge CLOCK);
            if (a_rd_valid === 1'b1) begin
                got_rd = 1'b1;
                if (rd_q.size() != 0) chk("rd_data", 32'(a_rd_data), 32'(rd_q.pop_front()));
                chk("rd_addr", 32'(a_addr), 32'd3);
                RD_REQ = 1'b0;
            end else if (a_busy === 1'b1) begin
                chk("rd_dq_oe", 32'({a_dq_oe, a_we_n, a_oe_n}), 32'b010);
            end
        end
        chk("rd_valid_seen", 32'(got_rd), 32'd1);
        RD_REQ = 1'b0;
        @(negedge CLOCK);
        chk("rd_addr_inc", 32'(a_addr), 32'd4);
        chk("rd_data_held", 32'(a_rd_data), 32'h21);
        chk("rd_valid_pulse", 32'(a_rd_valid), 32'd0);

        // Top address: saturate vs wrap.
        ADDR_LOAD = 1'b1; ADDR_VAL = 19'h7FFFF;
        @(negedge CLOCK);
        ADDR_LOAD = 1'b0;
        chk("top_load_sat", 32'(a_addr), 32'h7FFFF);
        chk("top_load_wrap", 32'(b_addr), 32'h7FFFF);
        WR_DATA[15:8] = 8'h77; WR_REQ = 2'b10;
        push_wr(1, 19'h7FFFF, 8'h77);
        wait_wr_ack(20, ack);
        if (ack != 2'b00) pop_wr(ack);
        WR_REQ = 2'b00;
        @(negedge CLOCK);
        chk("sat_full", 32'({a_full, a_empty, a_wrapped}), 32'b100);
        chk("sat_addr", 32'(a_addr), 32'h7FFFF);
        chk("wrap_addr", 32'(b_addr), 32'd0);
        chk("wrap_flags", 32'({b_wrapped, b_empty, b_full}), 32'b110);

        // Write while FULL: dropped, acked one cycle after the IDLE sample.
        WR_DATA[7:0] = 8'h88; WR_REQ = 2'b01;
        @(negedge CLOCK);
        chk("ovr_ack_next", 32'(a_wr_ack), 32'b01);
        WR_REQ = 2'b00;
        @(negedge CLOCK);
        chk("ovr_flags", 32'({a_overrun, a_full, a_busy, a_wr_ack}), 32'b11000);
        chk("ovr_addr", 32'(a_addr), 32'h7FFFF);
        chk("ovr_mem_kept", 32'(mem.exists(19'h7FFFF) ? mem[19'h7FFFF] : 8'h00), 32'h77);
        for (int i = 0; i < 20 && (a_busy || b_busy); i++) @(negedge CLOCK);
        chk("drain_idle", 32'({a_busy, b_busy}), 32'd0);

        // Load clears flags; load during WRITE is deferred to IDLE.
        ADDR_LOAD = 1'b1; ADDR_VAL = 19'd0;
        @(negedge CLOCK);
        ADDR_LOAD = 1'b0;
        chk("load_clears", 32'({a_full, a_overrun, a_empty, a_addr}), 32'h80000);
        chk("load_clears_wrap", 32'({b_wrapped, b_empty}), 32'b01);
        WR_DATA[7:0] = 8'h3C; WR_REQ = 2'b01;
        push_wr(0, 19'd0, 8'h3C);
        wait_we_low(20);
        ADDR_LOAD = 1'b1; ADDR_VAL = 19'h00100;
        @(negedge CLOCK);
        ADDR_LOAD = 1'b0;
        pop_wr(a_wr_ack);
        WR_REQ = 2'b00;
        repeat (2) @(negedge CLOCK);
        chk("pend_load_addr", 32'(a_addr), 32'h100);
        chk("pend_load_idle", 32'(a_busy), 32'd0);

        // Reset in the middle of WRITE aborts the access.
        WR_DATA[15:8] = 8'h99; WR_REQ = 2'b10;
        wait_we_low(20);
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("abort_strobes", 32'({a_we_n, a_oe_n, a_dq_oe, a_busy}), 32'b1000);
        chk("abort_counter", 32'({a_empty, a_addr}), 32'h80000);
        RESET = 1'b0; WR_REQ = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK);
            chk("abort_no_ack", 32'(a_wr_ack), 32'd0);
        end
        chk("sb_drained", 32'(wr_q.size() + rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
